alarm_controller: RTL and testbench

- Alarm unit directly downstream of the time-of-day counter.
- Consumes the running hour, minute and second values, plus a one-cycle per-second strobe, on the fast system clock.
- Holds a user-set alarm time, rings for a bounded duration, and supports snooze and stop.
- Drives the buzzer and the ringing/snoozed status used by the display stage.

---
 rtl/alarm_if.sv | 36 +++
 rtl/alarm_controller.sv | 151 +++++++++++++++
 tb/tb_alarm_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alarm_if.sv
// ============================================================================
// alarm_if : time-of-day, button and status bundle for alarm_controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface alarm_if;
   logic        sec_tick;
   logic [10:0] hour;
   logic [10:0] minute;
   logic [10:0] second;
   logic        alarm_en;
   logic        set_hour_btn;
   logic        set_min_btn;
   logic        snooze_btn;
   logic        stop_btn;
   logic [4:0]  alarm_hour;
   logic [5:0]  alarm_minute;
   logic        ringing;
   logic        snoozed;
   logic        buzzer;

   modport master (
      output sec_tick, hour, minute, second, alarm_en,
             set_hour_btn, set_min_btn, snooze_btn, stop_btn,
      input  alarm_hour, alarm_minute, ringing, snoozed, buzzer
   );

   modport slave (
      input  sec_tick, hour, minute, second, alarm_en,
             set_hour_btn, set_min_btn, snooze_btn, stop_btn,
      output alarm_hour, alarm_minute, ringing, snoozed, buzzer
   );
endinterface

`default_nettype wire

// File: rtl/alarm_controller.sv
// ============================================================================
// alarm_controller : alarm time storage, ring/snooze/stop sequencing, buzzer
// Rev 1.0
// ============================================================================
`default_nettype none

module alarm_controller #(
   parameter int RING_SECS      = 60,
   parameter int SNOOZE_MIN     = 5,
   parameter int RST_ALARM_HOUR = 7,
   parameter int RST_ALARM_MIN  = 0
) (
   input  wire logic clk,
   input  wire logic rst_n,
   alarm_if.slave    io
);

   localparam int c_SNZ_TICKS = SNOOZE_MIN * 60;
   localparam int c_RW        = $clog2(RING_SECS + 1);
   localparam int c_SW        = $clog2(c_SNZ_TICKS + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_RINGING = 2'd2,
      S_SNOOZE  = 2'd3
   } state_t;

   state_t            r_state,      w_state_nxt;
   logic [c_RW-1:0]   r_ring_cnt,   w_ring_cnt_nxt, w_ring_inc;
   logic [c_SW-1:0]   r_snz_cnt,    w_snz_cnt_nxt,  w_snz_inc;
   logic              r_buzzer,     w_buzzer_nxt;
   logic [4:0]        r_alarm_hour, w_hour_nxt;
   logic [5:0]        r_alarm_min,  w_min_nxt;
   logic              w_match;
   logic              w_set_ok;

   assign w_ring_inc = r_ring_cnt + c_RW'(1);
   assign w_snz_inc  = r_snz_cnt + c_SW'(1);

   // Compare against the stored (pre-update) alarm time on the full input width.
   assign w_match = io.sec_tick
                 && (io.hour   == {6'd0, r_alarm_hour})
                 && (io.minute == {5'd0, r_alarm_min})
                 && (io.second == 11'd0);

   assign w_set_ok = (r_state == S_IDLE) || (r_state == S_ARMED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ring_cnt   <= '0;
         r_snz_cnt    <= '0;
         r_buzzer     <= 1'b0;
         r_alarm_hour <= 5'(RST_ALARM_HOUR);
         r_alarm_min  <= 6'(RST_ALARM_MIN);
      end else begin
         r_state      <= w_state_nxt;
         r_ring_cnt   <= w_ring_cnt_nxt;
         r_snz_cnt    <= w_snz_cnt_nxt;
         r_buzzer     <= w_buzzer_nxt;
         r_alarm_hour <= w_hour_nxt;
         r_alarm_min  <= w_min_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ring_cnt_nxt = r_ring_cnt;
      w_snz_cnt_nxt  = r_snz_cnt;
      w_buzzer_nxt   = r_buzzer;

      if (!io.alarm_en) begin
         w_state_nxt    = S_IDLE;
         w_ring_cnt_nxt = '0;
         w_snz_cnt_nxt  = '0;
         w_buzzer_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
               if (w_match) begin
                  w_state_nxt    = S_RINGING;
                  w_ring_cnt_nxt = '0;
                  w_buzzer_nxt   = 1'b1;
               end
            end
            S_RINGING: begin
               // Stop outranks snooze when both arrive together.
               if (io.stop_btn) begin
                  w_state_nxt    = S_ARMED;
                  w_ring_cnt_nxt = '0;
                  w_buzzer_nxt   = 1'b0;
               end else if (io.snooze_btn) begin
                  w_state_nxt    = S_SNOOZE;
                  w_ring_cnt_nxt = '0;
                  w_snz_cnt_nxt  = '0;
                  w_buzzer_nxt   = 1'b0;
               end else if (io.sec_tick) begin
                  if (w_ring_inc == c_RW'(RING_SECS)) begin
                     w_state_nxt    = S_ARMED;
                     w_ring_cnt_nxt = '0;
                     w_buzzer_nxt   = 1'b0;
                  end else begin
                     w_ring_cnt_nxt = w_ring_inc;
                     w_buzzer_nxt   = ~r_buzzer;
                  end
               end
            end
            S_SNOOZE: begin
               if (io.stop_btn) begin
                  w_state_nxt   = S_ARMED;
                  w_snz_cnt_nxt = '0;
               end else if (io.sec_tick) begin
                  if (w_snz_inc == c_SW'(c_SNZ_TICKS)) begin
                     w_state_nxt    = S_RINGING;
                     w_snz_cnt_nxt  = '0;
                     w_ring_cnt_nxt = '0;
                     w_buzzer_nxt   = 1'b1;
                  end else begin
                     w_snz_cnt_nxt = w_snz_inc;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_hour_nxt = r_alarm_hour;
      w_min_nxt  = r_alarm_min;
      if (w_set_ok && io.set_hour_btn)
         w_hour_nxt = (r_alarm_hour == 5'd23) ? 5'd0 : r_alarm_hour + 5'd1;
      if (w_set_ok && io.set_min_btn)
         w_min_nxt = (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
   end

   assign io.alarm_hour   = r_alarm_hour;
   assign io.alarm_minute = r_alarm_min;
   assign io.ringing      = (r_state == S_RINGING);
   assign io.snoozed      = (r_state == S_SNOOZE);
   assign io.buzzer       = r_buzzer;

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// ============================================================================
// tb_alarm_controller : vector table plus scripted sequences, scoreboard check
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alarm_controller;

   typedef struct packed {
      logic        tick;
      logic [10:0] h;
      logic [10:0] m;
      logic [10:0] s;
      logic        en;
      logic        sh;
      logic        sm;
      logic        sn;
      logic        st;
      logic        er;
      logic        es;
      logic        eb;
      logic [4:0]  eh;
      logic [5:0]  em;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   vec_t sb[$];
   vec_t tbl [0:10];

   alarm_if u_if ();

   alarm_controller #(
      .RING_SECS      (4),
      .SNOOZE_MIN     (1),
      .RST_ALARM_HOUR (7),
      .RST_ALARM_MIN  (0)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (u_if)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic tick, input int h, input int m, input int s,
                               input logic en, input logic sh, input logic sm,
                               input logic sn, input logic st, input logic er,
                               input logic es, input logic eb, input int eh, input int em);
      vec_t v;
      v.tick = tick; v.h = 11'(h); v.m = 11'(m); v.s = 11'(s);
      v.en = en; v.sh = sh; v.sm = sm; v.sn = sn; v.st = st;
      v.er = er; v.es = es; v.eb = eb; v.eh = 5'(eh); v.em = 6'(em);
      return v;
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got ring/snz/buz/hr/min=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                    name, act[13], act[12], act[11], act[10:6], act[5:0],
                    exp[13], exp[12], exp[11], exp[10:6], exp[5:0]);
   endtask

   task automatic step(input vec_t v, input string name);
      vec_t e;
      @(negedge clk);
      u_if.sec_tick     = v.tick;
      u_if.hour         = v.h;
      u_if.minute       = v.m;
      u_if.second       = v.s;
      u_if.alarm_en     = v.en;
      u_if.set_hour_btn = v.sh;
      u_if.set_min_btn  = v.sm;
      u_if.snooze_btn   = v.sn;
      u_if.stop_btn     = v.st;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(name, {u_if.ringing, u_if.snoozed, u_if.buzzer, u_if.alarm_hour, u_if.alarm_minute},
            {e.er, e.es, e.eb, e.eh, e.em});
   endtask

   initial begin
      // Trigger at 07:00:00, buzzer 1,0,1,0 then auto-stop on 4th tick; then snooze entry.
      tbl[0]  = mk(0, 6, 59, 59, 1, 0, 0, 0, 0,  0, 0, 0, 7, 0);
      tbl[1]  = mk(1, 7, 0, 0,   1, 0, 0, 0, 0,  1, 0, 1, 7, 0);
      tbl[2]  = mk(1, 7, 0, 1,   1, 0, 0, 0, 0,  1, 0, 0, 7, 0);
      tbl[3]  = mk(0, 7, 0, 1,   1, 0, 0, 0, 0,  1, 0, 0, 7, 0);
      tbl[4]  = mk(1, 7, 0, 2,   1, 0, 0, 0, 0,  1, 0, 1, 7, 0);
      tbl[5]  = mk(1, 7, 0, 3,   1, 0, 0, 0, 0,  1, 0, 0, 7, 0);
      tbl[6]  = mk(1, 7, 0, 4,   1, 0, 0, 0, 0,  0, 0, 0, 7, 0);
      tbl[7]  = mk(1, 7, 0, 5,   1, 0, 0, 1, 1,  0, 0, 0, 7, 0);
      tbl[8]  = mk(1, 7, 0, 0,   1, 0, 0, 0, 0,  1, 0, 1, 7, 0);
      tbl[9]  = mk(0, 7, 0, 0,   1, 0, 0, 1, 0,  0, 1, 0, 7, 0);
      tbl[10] = mk(1, 7, 1, 1,   1, 0, 0, 1, 0,  0, 1, 0, 7, 0);

      u_if.sec_tick = 0; u_if.hour = 0; u_if.minute = 0; u_if.second = 0;
      u_if.alarm_en = 0; u_if.set_hour_btn = 0; u_if.set_min_btn = 0;
      u_if.snooze_btn = 0; u_if.stop_btn = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_values", {u_if.ringing, u_if.snoozed, u_if.buzzer, u_if.alarm_hour, u_if.alarm_minute},
            {1'b0, 1'b0, 1'b0, 5'd7, 6'd0});
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) step(tbl[i], $sformatf("tbl%0d", i));

      // Snooze runs 60 ticks; set_hour is locked out meanwhile.
      for (int i = 2; i < 60; i++)
         step(mk(1, 7, 1, i, 1, (i == 30), 0, 0, 0, 0, 1, 0, 7, 0), $sformatf("snooze_t%0d", i));
      step(mk(1, 7, 2, 0, 1, 0, 0, 0, 0, 1, 0, 1, 7, 0), "snooze_expiry");
      step(mk(1, 7, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 7, 0), "match_while_ringing");
      step(mk(0, 7, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 7, 0), "set_hour_lockout");
      step(mk(0, 7, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 7, 0), "stop_beats_snooze");

      step(mk(1, 7, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 7, 0), "ring_again");
      step(mk(0, 7, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 7, 0), "snooze_again");
      step(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0), "disable_in_snooze");
      for (int i = 0; i < 61; i++)
         step(mk(1, 7, 0, i % 60, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0), $sformatf("idle_t%0d", i));

      for (int i = 0; i < 17; i++)
         step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, (8 + i) % 24, 0), $sformatf("set_hour%0d", i));
      for (int i = 0; i < 60; i++)
         step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, (i + 1) % 60), $sformatf("set_min%0d", i));
      step(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1), "set_both");

      // Alarm is 01:01; arming mid-minute must not ring this minute or at the next.
      step(mk(1, 1, 1, 30, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), "arm_mid_minute");
      for (int s = 31; s < 60; s++)
         step(mk(1, 1, 1, s, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), $sformatf("mid_s%0d", s));
      step(mk(1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), "next_minute_quiet");
      step(mk(1, 1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 2), "set_on_match_old_value");
      step(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 2), "ring_tick_after_set");

      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_mid_ring", {u_if.ringing, u_if.snoozed, u_if.buzzer, u_if.alarm_hour, u_if.alarm_minute},
            {1'b0, 1'b0, 1'b0, 5'd7, 6'd0});
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
